// File: rtl/pattern_pkg.sv
// Shared types and pixel-format constants for the synthetic pattern framebuffer.
package pattern_pkg;

    typedef enum logic [1:0] {PAT_OFF, PAT_ON, PAT_WALK, PAT_GRAD} pattern_t;
    typedef enum logic {ST_IDLE, ST_STREAM} fb_state_t;

    localparam int BITS_PER_LED    = 48;
    localparam int LEDS_PER_DRIVER = 16;
    localparam int COLUMN_BITS     = 6144;
    localparam int DEF_MUX_LINES   = COLUMN_BITS / (LEDS_PER_DRIVER * BITS_PER_LED);
    localparam int LED_W           = $clog2(LEDS_PER_DRIVER);
    localparam int BIT_W           = $clog2(BITS_PER_LED);

    // Gradient intensity is the LED index placed in the top nibble of each colour.
    function automatic logic grad_bit(input logic [3:0] led, input logic [3:0] k);
        logic [15:0] v;
        v = {led, 12'h000};
        return v[k];
    endfunction

endpackage

// File: rtl/pattern_bit_gen.sv
// One lane of the test-pattern generator: the bit this lane drives for a given
// LED / bit position of the current column.
module pattern_bit_gen
    import pattern_pkg::*;
#(
    parameter int LANE = 0
) (
    input  pattern_t         i_mode,
    input  logic [LED_W-1:0] i_led,
    input  logic [3:0]       i_k,
    input  logic [3:0]       i_col_lsb,
    output logic             o_bit
);

    localparam logic [3:0] LANE_OFS = 4'(LANE % 16);

    // Each lane lights a different LED so the lit diagonal walks with the column.
    logic [3:0] w_walk_led;
    assign w_walk_led = i_col_lsb + LANE_OFS;

    always_comb begin
        o_bit = 1'b0;
        case (i_mode)
            PAT_OFF:  o_bit = 1'b0;
            PAT_ON:   o_bit = 1'b1;
            PAT_WALK: o_bit = (i_led == w_walk_led);
            PAT_GRAD: o_bit = grad_bit(i_led, i_k);
            default:  o_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/pattern_framebuffer.sv
// Synthetic framebuffer source: streams one column of a selectable test pattern,
// one bit per driver lane per consumer strobe.
module pattern_framebuffer
    import pattern_pkg::*;
#(
    parameter int NB_LANES   = 30,
    parameter int MUX_LINES  = DEF_MUX_LINES,
    parameter int NB_COLUMNS = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          column_ready,
    input  logic                          position_sync,
    input  logic                          bit_strobe,
    input  logic [1:0]                    mode,
    output logic [NB_LANES-1:0]           framebuffer_dat,
    output logic                          busy,
    output logic                          column_done,
    output logic [$clog2(NB_COLUMNS)-1:0] column_idx,
    output logic                          overrun
);

    localparam int COL_W  = $clog2(NB_COLUMNS);
    localparam int LINE_W = (MUX_LINES > 1) ? $clog2(MUX_LINES) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NB_COLUMNS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(MUX_LINES - 1);
    localparam logic [LED_W-1:0]  LED_FIRST = LED_W'(LEDS_PER_DRIVER - 1);
    localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(BITS_PER_LED - 1);

    fb_state_t          r_state;
    fb_state_t          w_state_next;
    logic               r_prev_ready;
    pattern_t           r_mode;
    pattern_t           w_mode_next;
    logic [COL_W-1:0]   r_col_idx;
    logic [COL_W-1:0]   w_col_next;
    logic [LINE_W-1:0]  r_line;
    logic [LINE_W-1:0]  w_line_next;
    logic [LED_W-1:0]   r_led;
    logic [LED_W-1:0]   w_led_next;
    logic [BIT_W-1:0]   r_bit;
    logic [BIT_W-1:0]   w_bit_next;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;
    logic               w_overrun_next;
    logic [NB_LANES-1:0] r_dat;
    logic [NB_LANES-1:0] w_lane_bits;

    logic w_start;
    logic w_last;
    logic w_consume_last;

    assign w_start        = column_ready & ~r_prev_ready;
    assign w_last         = (r_line == LINE_LAST) && (r_led == '0) && (r_bit == '0);
    assign w_consume_last = (r_state == ST_STREAM) && bit_strobe && w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_next = ST_STREAM;
            ST_STREAM: if (w_consume_last) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Next-value logic for the column parameters and the bit/LED/line position.
    always_comb begin
        w_mode_next    = r_mode;
        w_col_next     = r_col_idx;
        w_line_next    = r_line;
        w_led_next     = r_led;
        w_bit_next     = r_bit;
        w_overrun_next = r_overrun;
        if (r_state == ST_IDLE) begin
            if (w_start) begin
                w_mode_next = pattern_t'(mode);
                if (position_sync || (r_col_idx == COL_LAST)) begin
                    w_col_next = '0;
                end else begin
                    w_col_next = r_col_idx + COL_W'(1);
                end
                w_line_next = '0;
                w_led_next  = LED_FIRST;
                w_bit_next  = BIT_FIRST;
            end
        end else begin
            if (w_start) begin
                w_overrun_next = 1'b1;
            end
            if (bit_strobe) begin
                if (r_bit != '0) begin
                    w_bit_next = r_bit - BIT_W'(1);
                end else begin
                    w_bit_next = BIT_FIRST;
                    if (r_led != '0) begin
                        w_led_next = r_led - LED_W'(1);
                    end else begin
                        w_led_next  = LED_FIRST;
                        w_line_next = (r_line == LINE_LAST) ? '0 : r_line + LINE_W'(1);
                    end
                end
            end
        end
    end

    // Lanes are evaluated on the next position so the output word is registered.
    generate
        for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
            pattern_bit_gen #(
                .LANE(gi)
            ) u_bit_gen (
                .i_mode    (w_mode_next),
                .i_led     (w_led_next),
                .i_k       (w_bit_next[3:0]),
                .i_col_lsb (w_col_next[3:0]),
                .o_bit     (w_lane_bits[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_ready <= 1'b1;
            r_mode       <= PAT_OFF;
            r_col_idx    <= COL_LAST;
            r_line       <= '0;
            r_led        <= '0;
            r_bit        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_dat        <= '0;
        end else begin
            r_prev_ready <= column_ready;
            r_mode       <= w_mode_next;
            r_col_idx    <= w_col_next;
            r_line       <= w_line_next;
            r_led        <= w_led_next;
            r_bit        <= w_bit_next;
            r_busy       <= (w_state_next == ST_STREAM);
            r_done       <= w_consume_last;
            r_overrun    <= w_overrun_next;
            r_dat        <= (w_state_next == ST_STREAM) ? w_lane_bits : '0;
        end
    end

    assign framebuffer_dat = r_dat;
    assign busy            = r_busy;
    assign column_done     = r_done;
    assign column_idx      = r_col_idx;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_pattern_framebuffer.sv
// Directed bench for pattern_framebuffer: streams whole columns with the strobe
// held high and compares words, timing and status flags against hand-derived values.
module tb_pattern_framebuffer;

    localparam logic [29:0] ONES = 30'h3FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        column_ready;
    logic        position_sync;
    logic        bit_strobe;
    logic [1:0]  mode;
    logic [29:0] framebuffer_dat;
    logic        busy;
    logic        column_done;
    logic [6:0]  column_idx;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pattern_framebuffer dut (
        .clk             (clk),
        .rst             (rst),
        .column_ready    (column_ready),
        .position_sync   (position_sync),
        .bit_strobe      (bit_strobe),
        .mode            (mode),
        .framebuffer_dat (framebuffer_dat),
        .busy            (busy),
        .column_done     (column_done),
        .column_idx      (column_idx),
        .overrun         (overrun)
    );

    // Called at a negedge; the posedge after return is the start edge.
    task automatic start_column(input logic [1:0] m, input logic sync);
        column_ready = 1'b0;
        @(negedge clk);
        mode          = m;
        position_sync = sync;
        column_ready  = 1'b1;
    endtask

    task automatic run_stream(output int busy_cnt, output int done_cnt, output int done_at);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 6150; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (column_done) begin
                done_cnt++;
                done_at = c;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; column_ready = 1'b1; position_sync = 1'b0; bit_strobe = 1'b1; mode = 2'd1;
        repeat (3) @(negedge clk);
        n_vec++; if (framebuffer_dat !== 30'h0) begin n_err++; $display("FAIL reset_dat: got %h expected 0", framebuffer_dat); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (column_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", column_done); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_vec++; if (column_idx !== 7'd127) begin n_err++; $display("FAIL reset_idx: got %0d expected 127", column_idx); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_ready_no_start: got busy=%b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_all_on();
        int bad = 0, busy_cnt = 0, done_cnt = 0, done_at = 0;
        start_column(2'd1, 1'b0);
        for (int c = 1; c <= 6150; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (framebuffer_dat !== ONES) bad++;
            end
            if (column_done) begin done_cnt++; done_at = c; end
            if (c == 1) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL on_busy_rise: got %b expected 1", busy); end
                n_vec++; if (column_idx !== 7'd0) begin n_err++; $display("FAIL on_idx_wrap: got %0d expected 0", column_idx); end
            end
            if (c == 6145) begin
                n_vec++; if (framebuffer_dat !== 30'h0) begin n_err++; $display("FAIL on_dat_after_done: got %h expected 0", framebuffer_dat); end
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL on_busy_after_done: got %b expected 0", busy); end
            end
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL on_words: got %0d bad words expected 0", bad); end
        n_vec++; if (busy_cnt !== 6144) begin n_err++; $display("FAIL on_busy_len: got %0d expected 6144", busy_cnt); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL on_done_count: got %0d expected 1", done_cnt); end
        n_vec++; if (done_at !== 6145) begin n_err++; $display("FAIL on_done_time: got %0d expected 6145", done_at); end
        $display("test_all_on: %0d busy cycles, done at %0d", busy_cnt, done_at);
    endtask

    task automatic test_gradient();
        int bad = 0, done_cnt = 0, k;
        logic [15:0] field5;
        logic [29:0] exp_w;
        field5 = 16'b0101_0000_0000_0000;
        start_column(2'd3, 1'b0);
        for (int c = 1; c <= 6150; c++) begin
            @(negedge clk);
            if (column_done) done_cnt++;
            if (c >= 481 && c <= 528) begin
                k = 15 - ((c - 481) % 16);
                exp_w = field5[k] ? ONES : 30'h0;
                if (framebuffer_dat !== exp_w) bad++;
            end
            if (c == 1) begin
                n_vec++; if (column_idx !== 7'd1) begin n_err++; $display("FAIL grad_idx: got %0d expected 1", column_idx); end
                n_vec++; if (framebuffer_dat !== ONES) begin n_err++; $display("FAIL grad_led15_b47: got %h expected %h", framebuffer_dat, ONES); end
            end
            if (c == 5) begin
                n_vec++; if (framebuffer_dat !== 30'h0) begin n_err++; $display("FAIL grad_led15_b43: got %h expected 0", framebuffer_dat); end
            end
            if (c == 49) begin
                n_vec++; if (framebuffer_dat !== ONES) begin n_err++; $display("FAIL grad_led14_b47: got %h expected %h", framebuffer_dat, ONES); end
            end
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL grad_led5_words: got %0d bad words expected 0", bad); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL grad_done_count: got %0d expected 1", done_cnt); end
        $display("test_gradient: led5 words checked");
    endtask

    task automatic test_walk();
        int bad = 0, done_cnt = 0, led;
        start_column(2'd2, 1'b1);
        for (int c = 1; c <= 6150; c++) begin
            @(negedge clk);
            if (column_done) done_cnt++;
            if (c <= 6144) begin
                led = 15 - (((c - 1) % 768) / 48);
                if (framebuffer_dat[0]  !== (led == 0))  bad++;
                if (framebuffer_dat[3]  !== (led == 3))  bad++;
                if (framebuffer_dat[29] !== (led == 13)) bad++;
            end
            if (c == 1) begin
                n_vec++; if (column_idx !== 7'd0) begin n_err++; $display("FAIL walk_sync_idx: got %0d expected 0", column_idx); end
            end
            if (c == 721) begin
                n_vec++; if (framebuffer_dat[0] !== 1'b1) begin n_err++; $display("FAIL walk_lane0_led0: got %b expected 1", framebuffer_dat[0]); end
            end
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL walk_sync_bits: got %0d bad bits expected 0", bad); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL walk_sync_done: got %0d expected 1", done_cnt); end

        bad = 0; done_cnt = 0;
        start_column(2'd2, 1'b0);
        for (int c = 1; c <= 6150; c++) begin
            @(negedge clk);
            if (column_done) done_cnt++;
            if (c == 200) position_sync = 1'b1;
            if (c <= 6144) begin
                led = 15 - (((c - 1) % 768) / 48);
                if (framebuffer_dat[0] !== (led == 1)) bad++;
                if (framebuffer_dat[3] !== (led == 4)) bad++;
            end
            if (c == 1) begin
                n_vec++; if (column_idx !== 7'd1) begin n_err++; $display("FAIL walk_next_idx: got %0d expected 1", column_idx); end
            end
            if (c == 673) begin
                n_vec++; if (framebuffer_dat[0] !== 1'b1) begin n_err++; $display("FAIL walk_lane0_led1: got %b expected 1", framebuffer_dat[0]); end
            end
            if (c == 6000) begin
                n_vec++; if (column_idx !== 7'd1) begin n_err++; $display("FAIL walk_midsync_idx: got %0d expected 1", column_idx); end
            end
        end
        position_sync = 1'b0;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL walk_next_bits: got %0d bad bits expected 0", bad); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL walk_next_done: got %0d expected 1", done_cnt); end
        $display("test_walk: two columns checked");
    endtask

    task automatic test_overrun();
        int bad = 0, busy_cnt = 0, done_cnt = 0, done_at = 0;
        start_column(2'd1, 1'b0);
        for (int c = 1; c <= 6150; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (framebuffer_dat !== ONES) bad++;
            end
            if (column_done) begin done_cnt++; done_at = c; end
            if (c == 50) mode = 2'd0;
            if (c == 98) column_ready = 1'b0;
            if (c == 99) begin
                n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_before_edge: got %b expected 0", overrun); end
            end
            if (c == 100) column_ready = 1'b1;
            if (c == 101) begin
                n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b expected 1", overrun); end
            end
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL ovr_words: got %0d bad words expected 0", bad); end
        n_vec++; if (busy_cnt !== 6144) begin n_err++; $display("FAIL ovr_busy_len: got %0d expected 6144", busy_cnt); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL ovr_done_count: got %0d expected 1", done_cnt); end
        n_vec++; if (done_at !== 6145) begin n_err++; $display("FAIL ovr_done_time: got %0d expected 6145", done_at); end
        repeat (5) @(negedge clk);
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_no_restart: got %b expected 0", busy); end
        $display("test_overrun: overrun=%b", overrun);
    endtask

    task automatic test_reset_midstream();
        int busy_cnt = 0, done_cnt = 0, done_at = 0;
        start_column(2'd1, 1'b0);
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (column_done) done_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        n_vec++; if (framebuffer_dat !== 30'h0) begin n_err++; $display("FAIL mid_rst_dat: got %h expected 0", framebuffer_dat); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_overrun: got %b expected 0", overrun); end
        n_vec++; if (column_idx !== 7'd127) begin n_err++; $display("FAIL mid_rst_idx: got %0d expected 127", column_idx); end
        if (column_done) done_cnt++;
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (column_done) done_cnt++;
        end
        n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d expected 0", done_cnt); end
        n_vec++; if (busy_cnt !== 0) begin n_err++; $display("FAIL mid_rst_held_ready: got %0d busy cycles expected 0", busy_cnt); end
        start_column(2'd1, 1'b0);
        run_stream(busy_cnt, done_cnt, done_at);
        n_vec++; if (busy_cnt !== 6144) begin n_err++; $display("FAIL mid_fresh_busy_len: got %0d expected 6144", busy_cnt); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL mid_fresh_done_count: got %0d expected 1", done_cnt); end
        n_vec++; if (done_at !== 6145) begin n_err++; $display("FAIL mid_fresh_done_time: got %0d expected 6145", done_at); end
        n_vec++; if (column_idx !== 7'd0) begin n_err++; $display("FAIL mid_fresh_idx: got %0d expected 0", column_idx); end
        $display("test_reset_midstream: fresh column %0d busy cycles", busy_cnt);
    endtask

    task automatic test_back_to_back();
        int busy_cnt, done_cnt, done_at;
        logic [6:0] exp_idx;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (column_idx !== 7'd127) begin n_err++; $display("FAIL b2b_reset_idx: got %0d expected 127", column_idx); end
        exp_idx = 7'd0;
        for (int col = 0; col < 4; col++) begin
            start_column(2'd0, 1'b0);
            run_stream(busy_cnt, done_cnt, done_at);
            n_vec++; if (column_idx !== exp_idx) begin n_err++; $display("FAIL b2b_idx%0d: got %0d expected %0d", col, column_idx, exp_idx); end
            n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL b2b_done%0d: got %0d expected 1", col, done_cnt); end
            n_vec++; if (framebuffer_dat !== 30'h0) begin n_err++; $display("FAIL b2b_dat%0d: got %h expected 0", col, framebuffer_dat); end
            $display("test_back_to_back: column %0d idx=%0d busy=%0d", col, column_idx, busy_cnt);
            exp_idx = exp_idx + 7'd1;
        end
    endtask

    initial begin
        test_reset();
        test_all_on();
        test_gradient();
        test_walk();
        test_overrun();
        test_reset_midstream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
